branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-stage dynamic branch predictor: a direct-mapped branch target buffer with 2-bit saturating direction counters, trained by execute-stage branch resolution. It is the producer side of the branch_taken path. Fetch gets a predicted next PC every cycle. Execute returns the resolved outcome, and the block flags mispredicts and supplies the corrected PC for the pipeline flush.

## Interface
Parameters:
- INDEX_BITS, 6, log2 of entry count (64 entries)
- XLEN, 32, PC/address width

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- fetch_pc  in  XLEN  PC being fetched this cycle
- predict_taken  out  1  fetch_pc predicted taken (combinational from stored state)
- predict_target  out  XLEN  predicted next PC: stored target if predict_taken, else fetch_pc+4
- update_valid  in  1  execute stage holds a resolved conditional branch (Branch asserted)
- update_pc  in  XLEN  PC of the resolving branch
- update_taken  in  1  resolved outcome (branch_taken)
- update_target  in  XLEN  computed branch target
- update_pred_taken  in  1  predict_taken value piped from fetch with this branch
- update_pred_target  in  XLEN  predict_target value piped from fetch with this branch
- mispredict  out  1  prediction wrong; pipeline must flush younger instructions
- redirect_pc  out  XLEN  correct next PC: update_target if update_taken, else update_pc+4

## Operation
- Index = pc[INDEX_BITS+1:2]. Tag = pc[XLEN-1:INDEX_BITS+2]. pc[1:0] is ignored.
- Each entry holds valid (1b), tag, target (XLEN), and a 2-bit counter.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup:
  - hit = valid & tag match at the fetch_pc index.
  - predict_taken = hit & counter[1].
  - predict_target = predict_taken ? target : fetch_pc+4. Add is mod 2^XLEN, so 0xFFFFFFFC+4 = 0.
- Update, taken when update_valid=1 and rst=0:
  - Hit (tag match at the update_pc index):
    - Counter increments if update_taken, decrements otherwise, saturating at 11 and 00.
    - Target is rewritten with update_target only when update_taken=1.
  - Miss and update_taken=1: allocate the entry and overwrite any existing entry. valid=1, tag written, target=update_target, counter=10.
  - Miss and update_taken=0: no state change.
- Mispredict (combinational):
  - mispredict = update_valid & ~rst & ((update_taken != update_pred_taken) | (update_taken & update_pred_target != update_target)).
  - redirect_pc is always driven as defined. It is meaningful only when mispredict=1.
- Reset:
  - All valid bits clear; all counters set to 01.
  - Tags and targets are don't-care.
  - Update inputs are ignored while rst=1.

## Timing
- Lookup has zero latency: predict_* are combinational in fetch_pc and the stored state, with no clock between.
- Update has one-cycle latency: a write on edge N is visible to lookups from the cycle after edge N.
- Same index read and written in one cycle: the lookup returns the pre-update contents. There is no write-to-read bypass.
- mispredict and redirect_pc are valid in the same cycle as update_valid. The pipeline flushes on the following edge.
- Outputs after reset:
  - predict_taken=0 and predict_target=fetch_pc+4.
  - mispredict=0 while rst=1 and until an update_valid arrives.
- Reset mid-operation: an update presented in the rst cycle is dropped. A prior edge's completed writes are also discarded, since all entries are invalidated.
- Aliasing: two PCs with the same index and different tags are handled as a miss. A taken outcome from either PC evicts the other.

## Test plan
- Reset, then fetch_pc=0x100 -> predict_taken=0, predict_target=0x104. Present update_valid=1, update_taken=0, pred_taken=0 -> mispredict=0.
- Cold taken branch: update_pc=0x100, update_taken=1, update_target=0x40, pred_taken=0 -> mispredict=1, redirect_pc=0x40. The following cycle, fetch_pc=0x100 -> predict_taken=1, predict_target=0x40.
- Saturation at 0x100:
  - Four taken updates -> counter=11.
  - Then one not-taken update -> still predicted taken (10).
  - A second not-taken -> predict_taken=0, predict_target=0x104.
  - Further not-taken updates hold the counter at 00.
- Target change: 0x100 entry is valid with counter 11 and target 0x40. Update taken with update_target=0x80 and pred_target=0x40 -> mispredict=1, redirect_pc=0x80. The next lookup returns 0x80.
- Alias eviction at INDEX_BITS=6:
  - 0x100 and 0x200 share index 0 with different tags.
  - Train 0x100 taken, then update 0x200 taken -> a lookup at 0x100 misses (predict_taken=0).
- Same-cycle read/write: fetch_pc=update_pc=0x100 on a cold taken update -> the same cycle shows predict_taken=0, and the next cycle shows 1. With rst=1 in the update cycle -> no allocation and mispredict=0.

Source files
------------

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Fetch-stage dynamic branch predictor: a direct-mapped branch target buffer
// whose entries carry a 2-bit saturating direction counter. Fetch looks up a
// predicted next PC combinationally every cycle. Execute reports each
// resolved conditional branch back; the block trains the table on the
// following edge and flags a mispredict (with the corrected PC) in the same
// cycle the resolution is presented.
//
// Ports:
//   clk                 clock, all state changes on the rising edge
//   rst                 synchronous active-high reset
//   fetch_pc            PC being fetched this cycle
//   predict_taken       fetch_pc is predicted taken
//   predict_target      predicted next PC (stored target or fetch_pc+4)
//   update_valid        execute stage holds a resolved conditional branch
//   update_pc           PC of the resolving branch
//   update_taken        resolved direction
//   update_target       computed branch target
//   update_pred_taken   predict_taken piped from fetch with this branch
//   update_pred_target  predict_target piped from fetch with this branch
//   mispredict          prediction was wrong, flush younger instructions
//   redirect_pc         correct next PC for the flush
// ---------------------------------------------------------------------------
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            predict_taken,
  output logic [XLEN-1:0] predict_target,
  input  logic            update_valid,
  input  logic [XLEN-1:0] update_pc,
  input  logic            update_taken,
  input  logic [XLEN-1:0] update_target,
  input  logic            update_pred_taken,
  input  logic [XLEN-1:0] update_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = XLEN - INDEX_BITS - 2;

  // Table storage. Only valid and the counters are reset; tag and target are
  // meaningless while valid is clear, so they are left unreset.
  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] fetch_idx;
  logic [TAG_BITS-1:0]   fetch_tag;
  logic                  fetch_hit;

  logic [INDEX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0]   upd_tag;
  logic                  upd_hit;
  logic [1:0]            ctr_next;
  logic                  upd_en;

  // Word-aligned PCs: bits [1:0] never take part in index or tag.
  assign fetch_idx = fetch_pc[INDEX_BITS+1:2];
  assign fetch_tag = fetch_pc[XLEN-1:INDEX_BITS+2];
  assign upd_idx   = update_pc[INDEX_BITS+1:2];
  assign upd_tag   = update_pc[XLEN-1:INDEX_BITS+2];

  assign upd_en = update_valid & ~rst;

  // Lookup reads the registered table directly, so a same-cycle update to the
  // same index is not visible until the next cycle.
  always_comb begin
    fetch_hit      = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    predict_taken  = fetch_hit & ctr_q[fetch_idx][1];
    predict_target = predict_taken ? target_q[fetch_idx] : fetch_pc + XLEN'(4);
  end

  // Saturating counter step for the entry being trained.
  always_comb begin
    upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    ctr_next = ctr_q[upd_idx];
    if (update_taken) begin
      if (ctr_q[upd_idx] != 2'b11) ctr_next = ctr_q[upd_idx] + 2'd1;
    end else begin
      if (ctr_q[upd_idx] != 2'b00) ctr_next = ctr_q[upd_idx] - 2'd1;
    end
  end

  // A wrong direction, or a taken branch whose target moved, both need a
  // flush. The resolved next PC is driven unconditionally.
  always_comb begin
    mispredict  = upd_en &
                  ((update_taken != update_pred_taken) |
                   (update_taken & (update_pred_target != update_target)));
    redirect_pc = update_taken ? update_target : update_pc + XLEN'(4);
  end

  // Valid bits and counters. Reset starts every counter at weak-not-taken.
  // A miss only allocates on a taken outcome, which also evicts any alias.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (upd_en) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_next;
      end else if (update_taken) begin
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= 2'b10;
      end
    end
  end

  // Tags and targets. A hit only refreshes the target on a taken outcome so a
  // not-taken resolution never clobbers a good target.
  always_ff @(posedge clk) begin
    if (!rst && update_valid) begin
      if (upd_hit) begin
        if (update_taken) target_q[upd_idx] <= update_target;
      end else if (update_taken) begin
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= update_target;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
//
// Drives one vector per clock cycle: inputs are applied just after the rising
// edge, expected outputs are queued at the same time, and the queue is
// popped and compared on the falling edge before the next write takes place.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic [XLEN-1:0] fetch_pc;
  logic            predict_taken;
  logic [XLEN-1:0] predict_target;
  logic            update_valid;
  logic [XLEN-1:0] update_pc;
  logic            update_taken;
  logic [XLEN-1:0] update_target;
  logic            update_pred_taken;
  logic [XLEN-1:0] update_pred_target;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;

  typedef struct {
    logic            rst;
    logic [XLEN-1:0] fetch_pc;
    logic            uv;
    logic [XLEN-1:0] upc;
    logic            ut;
    logic [XLEN-1:0] utgt;
    logic            upt;
    logic [XLEN-1:0] uptgt;
    logic            e_pt;
    logic [XLEN-1:0] e_ptgt;
    logic            e_mis;
    logic [XLEN-1:0] e_redir;
  } vec_t;

  vec_t vecs[$];
  vec_t expq[$];
  int   checks = 0;
  int   errors = 0;

  branch_predictor #(.INDEX_BITS(6), .XLEN(XLEN)) dut (
    .clk                (clk),
    .rst                (rst),
    .fetch_pc           (fetch_pc),
    .predict_taken      (predict_taken),
    .predict_target     (predict_target),
    .update_valid       (update_valid),
    .update_pc          (update_pc),
    .update_taken       (update_taken),
    .update_target      (update_target),
    .update_pred_taken  (update_pred_taken),
    .update_pred_target (update_pred_target),
    .mispredict         (mispredict),
    .redirect_pc        (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Builds an update vector.
  function automatic vec_t upd(input logic r, input logic [XLEN-1:0] f,
                               input logic [XLEN-1:0] pc, input logic t,
                               input logic [XLEN-1:0] tgt, input logic pt,
                               input logic [XLEN-1:0] ptgt,
                               input logic e_pt, input logic [XLEN-1:0] e_ptgt,
                               input logic e_mis, input logic [XLEN-1:0] e_redir);
    vec_t v;
    v.rst = r; v.fetch_pc = f; v.uv = 1'b1; v.upc = pc; v.ut = t;
    v.utgt = tgt; v.upt = pt; v.uptgt = ptgt; v.e_pt = e_pt;
    v.e_ptgt = e_ptgt; v.e_mis = e_mis; v.e_redir = e_redir;
    return v;
  endfunction

  // Builds a lookup-only vector; idle update side resolves to 0+4.
  function automatic vec_t look(input logic r, input logic [XLEN-1:0] f,
                                input logic e_pt, input logic [XLEN-1:0] e_ptgt);
    vec_t v;
    v.rst = r; v.fetch_pc = f; v.uv = 1'b0; v.upc = '0; v.ut = 1'b0;
    v.utgt = '0; v.upt = 1'b0; v.uptgt = '0; v.e_pt = e_pt;
    v.e_ptgt = e_ptgt; v.e_mis = 1'b0; v.e_redir = 32'h4;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst                = v.rst;
    fetch_pc           = v.fetch_pc;
    update_valid       = v.uv;
    update_pc          = v.upc;
    update_taken       = v.ut;
    update_target      = v.utgt;
    update_pred_taken  = v.upt;
    update_pred_target = v.uptgt;
    expq.push_back(v);
  endtask

  task automatic checkOne(input string name, input logic [XLEN-1:0] act,
                          input logic [XLEN-1:0] exp, input int idx);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    @(negedge clk);
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard vec %0d: got empty queue expected entry", idx);
    end else begin
      e = expq.pop_front();
      checkOne("predict_taken",  {31'd0, predict_taken}, {31'd0, e.e_pt}, idx);
      checkOne("predict_target", predict_target,         e.e_ptgt,        idx);
      checkOne("mispredict",     {31'd0, mispredict},    {31'd0, e.e_mis}, idx);
      checkOne("redirect_pc",    redirect_pc,            e.e_redir,       idx);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Initial reset with an update that must be dropped.
    vecs.push_back(upd(1, 32'h100, 32'h100, 1, 32'h40, 0, 32'h104, 0, 32'h104, 0, 32'h40));
    vecs.push_back(look(0, 32'h100, 0, 32'h104));
    // Cold not-taken: no allocation, no mispredict.
    vecs.push_back(upd(0, 32'h100, 32'h100, 0, 32'h0, 0, 32'h104, 0, 32'h104, 0, 32'h104));
    // Cold taken with same-cycle lookup still showing the old state.
    vecs.push_back(upd(0, 32'h100, 32'h100, 1, 32'h40, 0, 32'h104, 0, 32'h104, 1, 32'h40));
    vecs.push_back(look(0, 32'h100, 1, 32'h40));
    // Four taken updates saturate the counter at strong-taken.
    for (int i = 0; i < 4; i++)
      vecs.push_back(upd(0, 32'h100, 32'h100, 1, 32'h40, 1, 32'h40, 1, 32'h40, 0, 32'h40));
    // Step down: 11 -> 10 still taken, 10 -> 01 not taken.
    vecs.push_back(upd(0, 32'h100, 32'h100, 0, 32'h40, 1, 32'h40, 1, 32'h40, 1, 32'h104));
    vecs.push_back(look(0, 32'h100, 1, 32'h40));
    vecs.push_back(upd(0, 32'h100, 32'h100, 0, 32'h40, 1, 32'h40, 1, 32'h40, 1, 32'h104));
    vecs.push_back(look(0, 32'h100, 0, 32'h104));
    // 01 -> 00, then held at 00.
    vecs.push_back(upd(0, 32'h100, 32'h100, 0, 32'h40, 0, 32'h104, 0, 32'h104, 0, 32'h104));
    vecs.push_back(upd(0, 32'h100, 32'h100, 0, 32'h40, 0, 32'h104, 0, 32'h104, 0, 32'h104));
    // One taken from 00 lands on 01, still not taken.
    vecs.push_back(upd(0, 32'h100, 32'h100, 1, 32'h40, 0, 32'h104, 0, 32'h104, 1, 32'h40));
    vecs.push_back(look(0, 32'h100, 0, 32'h104));
    vecs.push_back(upd(0, 32'h100, 32'h100, 1, 32'h40, 0, 32'h104, 0, 32'h104, 1, 32'h40));
    vecs.push_back(upd(0, 32'h100, 32'h100, 1, 32'h40, 1, 32'h40, 1, 32'h40, 0, 32'h40));
    // Target change on a strongly taken entry.
    vecs.push_back(upd(0, 32'h100, 32'h100, 1, 32'h80, 1, 32'h40, 1, 32'h40, 1, 32'h80));
    vecs.push_back(look(0, 32'h100, 1, 32'h80));
    // Alias at index 0 evicts 0x100.
    vecs.push_back(upd(0, 32'h100, 32'h200, 1, 32'h300, 0, 32'h204, 1, 32'h80, 1, 32'h300));
    vecs.push_back(look(0, 32'h100, 0, 32'h104));
    vecs.push_back(look(0, 32'h200, 1, 32'h300));
    // Wraparound of both +4 adders.
    vecs.push_back(look(0, 32'hFFFF_FFFC, 0, 32'h0));
    vecs.push_back(upd(0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0));
    // Mid-operation reset discards trained state and drops the update.
    vecs.push_back(upd(1, 32'h500, 32'h200, 1, 32'h300, 0, 32'h204, 0, 32'h504, 0, 32'h300));
    vecs.push_back(look(0, 32'h200, 0, 32'h204));
    // Non-zero index allocation and neighbour isolation.
    vecs.push_back(upd(0, 32'h104, 32'h1234, 1, 32'hABC0, 0, 32'h1238, 0, 32'h108, 1, 32'hABC0));
    vecs.push_back(look(0, 32'h1234, 1, 32'hABC0));
    vecs.push_back(look(0, 32'h1238, 0, 32'h123C));

    rst = 1'b1; fetch_pc = '0; update_valid = 1'b0; update_pc = '0;
    update_taken = 1'b0; update_target = '0; update_pred_taken = 1'b0;
    update_pred_target = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i);
    end

    // Hand sequence: a completed write followed by a reset cycle is lost.
    applyStimulus(upd(0, 32'h300, 32'h300, 1, 32'h900, 0, 32'h304, 0, 32'h304, 1, 32'h900));
    checkOutput(100);
    applyStimulus(look(1, 32'h0, 0, 32'h4));
    checkOutput(101);
    applyStimulus(look(0, 32'h300, 0, 32'h304));
    checkOutput(102);
    applyStimulus(look(0, 32'h1234, 0, 32'h1238));
    checkOutput(103);

    // Hand sequence: reset held two cycles, then a fresh allocation works.
    applyStimulus(upd(1, 32'h40, 32'h40, 1, 32'h10, 0, 32'h44, 0, 32'h44, 0, 32'h10));
    checkOutput(104);
    applyStimulus(upd(1, 32'h40, 32'h40, 1, 32'h10, 0, 32'h44, 0, 32'h44, 0, 32'h10));
    checkOutput(105);
    applyStimulus(upd(0, 32'h40, 32'h40, 1, 32'h10, 0, 32'h44, 0, 32'h44, 1, 32'h10));
    checkOutput(106);
    applyStimulus(look(0, 32'h40, 1, 32'h10));
    checkOutput(107);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
